dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data RAM.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: requester presents a load/store.
REQ-006 SHALL have port req_ready, output, 1: responder accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-010 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port req_unsigned, input, 1: zero-extend load (LBU/LHU).
REQ-012 SHALL have port resp_valid, output, 1: response available.
REQ-013 SHALL have port resp_ready, input, 1: requester consumes the response.
REQ-014 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err, output, 1: misaligned, illegal-size or out-of-range request.

Function
REQ-016 SHALL implement FSM states IDLE, READ, RESP; only one request outstanding.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-018 SHALL flag an error when size=11, half with addr[0]=1, word with addr[1:0]!=0, or the word index (addr-BASE_ADDR)>>2 >= DEPTH_WORDS or addr<BASE_ADDR.
REQ-019 On an accepted error request: no RAM access, next state RESP, resp_err=1, resp_rdata=0.
REQ-020 On an accepted legal store: RAM written at that same edge with byte enables (byte: 1 lane at addr[1:0]; half: 2 lanes at addr[1]; word: all 4), write data replicated to lanes; next state RESP, resp_err=0.
REQ-021 On an accepted legal load: RAM read issued at that edge, next state READ; in READ, select the lane(s) by latched addr[1:0], sign/zero-extend by latched size/unsigned, register into resp_rdata, next state RESP.
REQ-022 Latency from accept edge to resp_valid high: store/error 1 cycle, load 2 cycles.
REQ-023 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL be held stable until resp_ready=1; on that edge go to IDLE.
REQ-024 resp_valid=0 in IDLE and READ; back-to-back throughput is one store per 2 cycles and one load per 3 cycles with resp_ready held high.
REQ-025 A load following a store to the same word SHALL return the stored data (write completes before the next accept).
REQ-026 req_* inputs SHALL be sampled only on the accept edge; changes afterwards have no effect.

Reset
REQ-027 When rst=1 at a posedge: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, latched request fields=0.
REQ-028 Reset mid-operation (READ or RESP) SHALL discard the pending response; an in-flight load causes no RAM change.
REQ-029 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W) and the state enum.
REQ-031 SHALL instantiate one sub-module dmem_sram: DEPTH_WORDS x 32, synchronous read (1-cycle), 4-bit byte-enable synchronous write.

Verification
REQ-032 Store word 32'hDEADBEEF to 0x10, then load word 0x10 -> resp_rdata=32'hDEADBEEF, err=0, load resp_valid 2 cycles after accept.
REQ-033 Store byte 8'h80 to 0x21, load byte 0x21 signed -> 32'hFFFFFF80; unsigned -> 32'h00000080; bytes 0x20/0x22/0x23 unchanged.
REQ-034 Load half at 0x13 -> resp_err=1, resp_rdata=0, 1-cycle latency, RAM unchanged; load at 4*DEPTH_WORDS -> resp_err=1.
REQ-035 Load with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held stable, req_ready=0 throughout; IDLE the cycle after resp_ready=1.
REQ-036 Assert rst while in READ -> next cycle IDLE, resp_valid=0, req_ready=1; earlier stored data still readable.
REQ-037 Store half 16'h1234 to 0x42, load word 0x40 -> upper 16 bits 16'h1234, lower half unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes, FSM states
// and the lane/extension helpers used by the request and response paths.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_H:    bad = lo[0];
            SZ_W:    bad = (lo != 2'b00);
            SZ_X:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_B:    be = 4'b0001 << lo;
            SZ_H:    be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Stores are right-aligned on the bus; copying them to every lane lets the
    // byte enables alone pick the destination.
    function automatic logic [31:0] replicate_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        r = wdata;
        case (size)
            SZ_B:    r = {4{wdata[7:0]}};
            SZ_H:    r = {2{wdata[15:0]}};
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lo,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {lo, 3'b000};
        b = shifted[7:0];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word RAM with a one-cycle registered read and per-byte write enables.
// Contents have no reset, so data survives a responder reset.
module dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder in front of a byte-enabled data RAM: one request in flight,
// stores and rejected requests answer after one cycle, loads after two.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        req_err;
    logic        accept;
    logic        sram_en;
    logic [3:0]  sram_be;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [31:0] rdata_d;

    // Range check is done on the full word index so addresses far past the RAM
    // cannot alias back onto it through the truncated SRAM address.
    always_comb begin
        offset     = req_addr - BASE_ADDR;
        word_idx   = offset >> 2;
        req_err    = is_misaligned(req_size, req_addr[1:0])
                   || (req_addr < BASE_ADDR)
                   || (word_idx >= 32'(DEPTH_WORDS));
        accept     = (state_q == IDLE) && req_valid && !rst;
        sram_en    = accept && !req_err;
        sram_be    = byte_enable(req_size, req_addr[1:0]);
        sram_wdata = replicate_wdata(req_size, req_wdata);
        rdata_d    = extend_load(sram_rdata, lo_q, size_q, uns_q);
    end

    dmem_sram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (req_we),
        .be    (sram_be),
        .addr  (word_idx[AW-1:0]),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            lo_q         <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        lo_q         <= req_addr[1:0];
                        size_q       <= req_size;
                        uns_q        <= req_unsigned;
                        resp_rdata_q <= '0;
                        resp_err_q   <= req_err;
                        if (req_err || req_we) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q      <= READ;
                        end
                    end
                end
                READ: begin
                    resp_rdata_q <= rdata_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
